dec_job_scheduler: RTL and testbench
====================================

DEC_JOB_SCHEDULER -- requirements
Module: dec_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_DEC, default 2, number of decompressor instances (1..8).
REQ-002 SHALL have parameter ADDR_W, default 64, host address width.
REQ-003 SHALL have parameter MAX_BEATS, default 64, maximum 64-byte beats per read burst (1..256).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port job_valid_i  in  1  new job offered.
REQ-007 SHALL have port job_ready_o  out  1  job accepted this cycle when high with job_valid_i.
REQ-008 SHALL have port job_src_addr_i  in  ADDR_W  compressed-data start address.
REQ-009 SHALL have port job_clen_i  in  32  compressed length in bytes.
REQ-010 SHALL have port dec_start_o  out  NUM_DEC  one-hot start pulse to the assigned decompressor.
REQ-011 SHALL have port dec_done_i  in  NUM_DEC  per-decompressor done pulse.
REQ-012 SHALL have port dec_almostempty_i  in  NUM_DEC  decompressor input FIFO can take a full burst.
REQ-013 SHALL have port rd_req_o  out  1  read-burst request.
REQ-014 SHALL have port rd_req_ack_i  in  1  request accepted.
REQ-015 SHALL have port rd_addr_o  out  ADDR_W  burst address, 64-byte aligned.
REQ-016 SHALL have port rd_len_o  out  8  beats minus one.
REQ-017 SHALL have port rd_data_valid_i  in  1  read beat valid.
REQ-018 SHALL have port rd_rlast_i  in  1  last beat of burst.
REQ-019 SHALL have port rd_grant_o  out  NUM_DEC  one-hot routing of read data to the decompressor owning the burst.
REQ-020 SHALL have port busy_o  out  NUM_DEC  decompressor holds an unfinished job.
REQ-021 SHALL have port all_idle_o  out  1  no decompressor busy and read FSM in IDLE.

Function
REQ-022 job_ready_o SHALL equal 1 whenever any busy_o bit is 0 (combinational).
REQ-023 On job_valid_i & job_ready_o the lowest-index non-busy decompressor k SHALL be loaded: busy_o[k] set, address register set to job_src_addr_i with bits [5:0] forced to 0, remaining-bytes register set to job_clen_i.
REQ-024 dec_start_o[k] SHALL pulse high exactly one cycle, the cycle after acceptance.
REQ-025 dec_done_i[k] SHALL clear busy_o[k] and its remaining count next cycle; dec_done_i on a non-busy index SHALL be ignored.
REQ-026 Read FSM states: IDLE, REQ, DATA.
REQ-027 IDLE: eligible k = busy_o[k] & remaining[k]!=0 & dec_almostempty_i[k]; if any eligible, select one (see Configuration), latch it as owner, go to REQ.
REQ-028 REQ: rd_req_o=1, rd_addr_o=owner address, beats=min(MAX_BEATS, ceil(remaining/64)), rd_len_o=beats-1; held stable until rd_req_ack_i, then go to DATA.
REQ-029 On ack: owner address += beats*64; remaining -= beats*64, saturating at 0.
REQ-030 DATA: rd_grant_o = one-hot owner; on rd_data_valid_i & rd_rlast_i return to IDLE next cycle; rd_grant_o=0 outside DATA.
REQ-031 Only one burst SHALL be outstanding at a time.
REQ-032 A job with job_clen_i=0 SHALL be loaded and started but never requested; busy until dec_done_i.
REQ-033 Job acceptance and dec_done_i SHALL be processed in the same cycle independently.
REQ-034 dec_done_i for the current owner during REQ/DATA SHALL NOT abort the burst; FSM completes it normally.

Reset
REQ-035 rst SHALL immediately clear FSM to IDLE, all busy, address and remaining registers, arbitration pointer; outputs job_ready_o=1, all other outputs 0, all_idle_o=1.
REQ-036 Reset mid-burst SHALL abandon the burst; upstream DMA is reset by the same signal.

Configuration
REQ-037 With DEC_SCHED_RR_EN defined, IDLE selection SHALL be round-robin: first eligible index after the last owner, wrapping at NUM_DEC-1 to 0; pointer resets to NUM_DEC-1.
REQ-038 Without DEC_SCHED_RR_EN, IDLE selection SHALL be fixed priority, lowest eligible index wins.

Verification
REQ-039 Job addr 0x1000, clen 200, dec0 almostempty -> one burst addr 0x1000 rd_len 3, grant 0b01 until rlast, remaining 0.
REQ-040 clen 5000, MAX_BEATS 64 -> bursts addr 0x0 len 63, addr 0x1000 len 14.
REQ-041 Two jobs back-to-back, both almostempty, DEC_SCHED_RR_EN -> grants alternate 0b01, 0b10; without macro dec0 bursts first until done.
REQ-042 Both busy -> job_ready_o=0; dec_done_i[1] pulse -> next job loads dec1, dec_start_o=0b10 one cycle later.
REQ-043 rst asserted in DATA -> rd_grant_o=0, busy_o=0, all_idle_o=1 without a clock edge.
REQ-044 clen 0 job -> dec_start_o pulse, no rd_req_o, busy until dec_done_i.

Source files
------------

// File: rtl/dec_job_scheduler.sv
// Dispatches decompression jobs to NUM_DEC decompressors and fetches their
// compressed input as 64-byte-beat read bursts, one burst in flight at a time.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   job_valid_i/ready_o    job handshake; job_src_addr_i, job_clen_i payload
//   dec_start_o            one-cycle one-hot start to the loaded decompressor
//   dec_done_i             per-decompressor completion pulse
//   dec_almostempty_i      decompressor can absorb a full burst
//   rd_req_o/rd_req_ack_i  burst request handshake; rd_addr_o, rd_len_o
//   rd_data_valid_i/rlast  read beat stream of the outstanding burst
//   rd_grant_o             one-hot routing of read data to the burst owner
//   busy_o, all_idle_o     status
//
// Build option: define DEC_SCHED_RR_EN for round-robin burst arbitration;
// otherwise the lowest eligible index always wins.

module dec_job_scheduler #(
  parameter int NUM_DEC   = 2,
  parameter int ADDR_W    = 64,
  parameter int MAX_BEATS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [ADDR_W-1:0] job_src_addr_i,
  input  logic [31:0]       job_clen_i,
  output logic [NUM_DEC-1:0] dec_start_o,
  input  logic [NUM_DEC-1:0] dec_done_i,
  input  logic [NUM_DEC-1:0] dec_almostempty_i,
  output logic              rd_req_o,
  input  logic              rd_req_ack_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [7:0]        rd_len_o,
  input  logic              rd_data_valid_i,
  input  logic              rd_rlast_i,
  output logic [NUM_DEC-1:0] rd_grant_o,
  output logic [NUM_DEC-1:0] busy_o,
  output logic              all_idle_o
);

  localparam int IW = (NUM_DEC > 1) ? $clog2(NUM_DEC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_DEC-1:0] busy_q, busy_d;
  logic [NUM_DEC-1:0] start_q, start_d;
  logic [ADDR_W-1:0]  addr_q [NUM_DEC];
  logic [ADDR_W-1:0]  addr_d [NUM_DEC];
  logic [31:0]        rem_q  [NUM_DEC];
  logic [31:0]        rem_d  [NUM_DEC];
  logic [IW-1:0]      owner_q, owner_d;
  // Owner still holds the job the burst was issued for; cleared when the
  // owner finishes mid-burst so a late ack cannot touch a reloaded slot.
  logic               live_q, live_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [8:0]         req_beats_q, req_beats_d;
`ifdef DEC_SCHED_RR_EN
  logic [IW-1:0]      ptr_q, ptr_d;
`endif

  logic [NUM_DEC-1:0] elig;
  logic               acc_hit;
  logic [IW-1:0]      acc_idx;
  logic               sel_hit;
  logic [IW-1:0]      sel_idx;
  logic [31:0]        step32;
  logic [ADDR_W-1:0]  step_a;

  function automatic logic [8:0] beats_of(input logic [31:0] r);
    logic [26:0] c;
    c = 27'((33'(r) + 33'd63) >> 6);
    if (c > 27'(MAX_BEATS)) return 9'(MAX_BEATS);
    return c[8:0];
  endfunction

  assign step32 = 32'({req_beats_q, 6'b0});
  assign step_a = ADDR_W'({req_beats_q, 6'b0});

  always_comb begin
    for (int i = 0; i < NUM_DEC; i++) begin
      elig[i] = busy_q[i] && (rem_q[i] != 32'd0)
                && dec_almostempty_i[i];
    end
  end

  always_comb begin
    acc_hit = 1'b0;
    acc_idx = '0;
    for (int i = NUM_DEC - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        acc_hit = 1'b1;
        acc_idx = IW'(i);
      end
    end
  end

  always_comb begin
    int j;
    j       = 0;
    sel_hit = 1'b0;
    sel_idx = '0;
`ifdef DEC_SCHED_RR_EN
    // Scan downward in offset so the nearest index after ptr_q wins.
    for (int off = NUM_DEC; off >= 1; off--) begin
      j = (int'(ptr_q) + off) % NUM_DEC;
      if (elig[j]) begin
        sel_hit = 1'b1;
        sel_idx = IW'(j);
      end
    end
`else
    for (int i = NUM_DEC - 1; i >= 0; i--) begin
      j = i;
      if (elig[j]) begin
        sel_hit = 1'b1;
        sel_idx = IW'(j);
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    start_d     = '0;
    addr_d      = addr_q;
    rem_d       = rem_q;
    owner_d     = owner_q;
    live_d      = live_q;
    req_addr_d  = req_addr_q;
    req_beats_d = req_beats_q;
`ifdef DEC_SCHED_RR_EN
    ptr_d       = ptr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (sel_hit) begin
          owner_d     = sel_idx;
          live_d      = 1'b1;
          req_addr_d  = addr_q[sel_idx];
          req_beats_d = beats_of(rem_q[sel_idx]);
          state_d     = S_REQ;
`ifdef DEC_SCHED_RR_EN
          ptr_d       = sel_idx;
`endif
        end
      end
      S_REQ: begin
        if (rd_req_ack_i) begin
          state_d = S_DATA;
          if (live_q) begin
            addr_d[owner_q] = addr_q[owner_q] + step_a;
            rem_d[owner_q]  = (rem_q[owner_q] > step32)
                              ? rem_q[owner_q] - step32 : 32'd0;
          end
        end
      end
      S_DATA: begin
        if (rd_data_valid_i && rd_rlast_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion wins over a same-cycle ack update of the owner.
    for (int i = 0; i < NUM_DEC; i++) begin
      if (dec_done_i[i] && busy_q[i]) begin
        busy_d[i] = 1'b0;
        rem_d[i]  = 32'd0;
        if (owner_d == IW'(i)) live_d = 1'b0;
      end
    end

    // acc_idx is never busy, so done/ack never collide with the load.
    if (job_valid_i && acc_hit) begin
      busy_d[acc_idx]  = 1'b1;
      start_d[acc_idx] = 1'b1;
      addr_d[acc_idx]  = job_src_addr_i & ~ADDR_W'(63);
      rem_d[acc_idx]   = job_clen_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= '0;
      start_q     <= '0;
      owner_q     <= '0;
      live_q      <= 1'b0;
      req_addr_q  <= '0;
      req_beats_q <= '0;
      for (int i = 0; i < NUM_DEC; i++) begin
        addr_q[i] <= '0;
        rem_q[i]  <= '0;
      end
`ifdef DEC_SCHED_RR_EN
      ptr_q       <= IW'(NUM_DEC - 1);
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      owner_q     <= owner_d;
      live_q      <= live_d;
      req_addr_q  <= req_addr_d;
      req_beats_q <= req_beats_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
`ifdef DEC_SCHED_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign job_ready_o = ~&busy_q;
  assign dec_start_o = start_q;
  assign busy_o      = busy_q;
  assign rd_req_o    = (state_q == S_REQ);
  assign rd_addr_o   = rd_req_o ? req_addr_q : '0;
  assign rd_len_o    = rd_req_o ? 8'(req_beats_q - 9'd1) : 8'd0;
  assign rd_grant_o  = (state_q == S_DATA)
                       ? (NUM_DEC'(1) << owner_q) : '0;
  assign all_idle_o  = ~|busy_q && (state_q == S_IDLE);

endmodule

// File: tb/tb_dec_job_scheduler.sv
// Directed bench for dec_job_scheduler (NUM_DEC=2, ADDR_W=64, MAX_BEATS=64).
// Table-driven single-burst vectors plus multi-cycle corner sequences.

module tb_dec_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [63:0] job_src_addr_i;
  logic [31:0] job_clen_i;
  logic [1:0]  dec_start_o;
  logic [1:0]  dec_done_i;
  logic [1:0]  dec_almostempty_i;
  logic        rd_req_o;
  logic        rd_req_ack_i;
  logic [63:0] rd_addr_o;
  logic [7:0]  rd_len_o;
  logic        rd_data_valid_i;
  logic        rd_rlast_i;
  logic [1:0]  rd_grant_o;
  logic [1:0]  busy_o;
  logic        all_idle_o;

  int checks = 0;
  int errors = 0;

  dec_job_scheduler #(
    .NUM_DEC(2), .ADDR_W(64), .MAX_BEATS(64)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_src_addr_i(job_src_addr_i), .job_clen_i(job_clen_i),
    .dec_start_o(dec_start_o), .dec_done_i(dec_done_i),
    .dec_almostempty_i(dec_almostempty_i),
    .rd_req_o(rd_req_o), .rd_req_ack_i(rd_req_ack_i),
    .rd_addr_o(rd_addr_o), .rd_len_o(rd_len_o),
    .rd_data_valid_i(rd_data_valid_i), .rd_rlast_i(rd_rlast_i),
    .rd_grant_o(rd_grant_o), .busy_o(busy_o), .all_idle_o(all_idle_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] a;
    logic [31:0] cl;
    logic [1:0]  ae;
    logic [1:0]  dn;
    logic        ack;
    logic        dv;
    logic        rl;
    logic        e_rdy;
    logic [1:0]  e_st;
    logic        e_req;
    logic [63:0] e_addr;
    logic [7:0]  e_len;
    logic [1:0]  e_gnt;
    logic [1:0]  e_busy;
    logic        e_idle;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic wait_req(input int lim);
    int n;
    n = 0;
    while (!rd_req_o && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", 64'(rd_req_o), 64'd1);
  endtask

  task automatic do_burst(output logic [1:0] g);
    rd_req_ack_i = 1'b1;
    @(negedge clk);
    rd_req_ack_i = 1'b0;
    g = rd_grant_o;
    rd_data_valid_i = 1'b1;
    rd_rlast_i = 1'b1;
    @(negedge clk);
    rd_data_valid_i = 1'b0;
    rd_rlast_i = 1'b0;
  endtask

  task automatic job(input logic [63:0] a, input logic [31:0] cl);
    job_valid_i = 1'b1;
    job_src_addr_i = a;
    job_clen_i = cl;
    @(negedge clk);
    job_valid_i = 1'b0;
  endtask

  logic [1:0]  g;
  logic [1:0]  exp_g [4];
  logic [63:0] exp_a [4];

  initial begin
    rst = 1'b1;
    job_valid_i = 1'b0;
    job_src_addr_i = '0;
    job_clen_i = '0;
    dec_done_i = '0;
    dec_almostempty_i = '0;
    rd_req_ack_i = 1'b0;
    rd_data_valid_i = 1'b0;
    rd_rlast_i = 1'b0;

    tbl[0] = '{1, 64'h1005, 200, 2'b01, 0, 0, 0, 0,
               1, 2'b01, 0, 64'h0, 8'd0, 2'b00, 2'b01, 0};
    tbl[1] = '{0, 64'h0, 0, 2'b01, 0, 0, 0, 0,
               1, 2'b00, 1, 64'h1000, 8'd3, 2'b00, 2'b01, 0};
    tbl[2] = '{0, 64'h0, 0, 2'b01, 0, 0, 0, 0,
               1, 2'b00, 1, 64'h1000, 8'd3, 2'b00, 2'b01, 0};
    tbl[3] = '{0, 64'h0, 0, 2'b01, 0, 1, 0, 0,
               1, 2'b00, 0, 64'h0, 8'd0, 2'b01, 2'b01, 0};
    tbl[4] = '{0, 64'h0, 0, 2'b01, 0, 0, 1, 0,
               1, 2'b00, 0, 64'h0, 8'd0, 2'b01, 2'b01, 0};
    tbl[5] = '{0, 64'h0, 0, 2'b01, 0, 0, 1, 1,
               1, 2'b00, 0, 64'h0, 8'd0, 2'b00, 2'b01, 0};
    tbl[6] = '{0, 64'h0, 0, 2'b01, 0, 0, 0, 0,
               1, 2'b00, 0, 64'h0, 8'd0, 2'b00, 2'b01, 0};
    tbl[7] = '{0, 64'h0, 0, 2'b01, 2'b01, 0, 0, 0,
               1, 2'b00, 0, 64'h0, 8'd0, 2'b00, 2'b00, 1};

    #1;
    chk("rst_ready", 64'(job_ready_o), 64'd1);
    chk("rst_start", 64'(dec_start_o), 64'd0);
    chk("rst_req",   64'(rd_req_o), 64'd0);
    chk("rst_grant", 64'(rd_grant_o), 64'd0);
    chk("rst_busy",  64'(busy_o), 64'd0);
    chk("rst_idle",  64'(all_idle_o), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single 200-byte job: one 4-beat burst to dec0.
    for (int i = 0; i < 8; i++) begin
      job_valid_i       = tbl[i].v;
      job_src_addr_i    = tbl[i].a;
      job_clen_i        = tbl[i].cl;
      dec_almostempty_i = tbl[i].ae;
      dec_done_i        = tbl[i].dn;
      rd_req_ack_i      = tbl[i].ack;
      rd_data_valid_i   = tbl[i].dv;
      rd_rlast_i        = tbl[i].rl;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 64'(job_ready_o), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_start", i), 64'(dec_start_o), 64'(tbl[i].e_st));
      chk($sformatf("v%0d_req", i),   64'(rd_req_o), 64'(tbl[i].e_req));
      chk($sformatf("v%0d_addr", i),  rd_addr_o, tbl[i].e_addr);
      chk($sformatf("v%0d_len", i),   64'(rd_len_o), 64'(tbl[i].e_len));
      chk($sformatf("v%0d_grant", i), 64'(rd_grant_o), 64'(tbl[i].e_gnt));
      chk($sformatf("v%0d_busy", i),  64'(busy_o), 64'(tbl[i].e_busy));
      chk($sformatf("v%0d_idle", i),  64'(all_idle_o), 64'(tbl[i].e_idle));
    end
    job_valid_i = 0; dec_done_i = 0; rd_req_ack_i = 0;
    rd_data_valid_i = 0; rd_rlast_i = 0;

    // 5000 bytes: 64-beat burst then 15-beat burst.
    dec_almostempty_i = 2'b01;
    job(64'h0, 32'd5000);
    wait_req(20);
    chk("b40_addr0", rd_addr_o, 64'h0);
    chk("b40_len0", 64'(rd_len_o), 64'd63);
    do_burst(g);
    chk("b40_gnt0", 64'(g), 64'h1);
    wait_req(20);
    chk("b40_addr1", rd_addr_o, 64'h1000);
    chk("b40_len1", 64'(rd_len_o), 64'd14);
    do_burst(g);
    repeat (3) @(negedge clk);
    chk("b40_noreq", 64'(rd_req_o), 64'd0);
    dec_done_i = 2'b01;
    @(negedge clk);
    dec_done_i = 2'b00;
    chk("b40_busy", 64'(busy_o), 64'd0);

    // Two jobs back-to-back, both decompressors can take data.
    dec_almostempty_i = 2'b11;
    job(64'h10000, 32'd5000);
    job(64'h20000, 32'd5000);
`ifdef DEC_SCHED_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_a = '{64'h10000, 64'h20000, 64'h11000, 64'h21000};
`else
    exp_g = '{2'b01, 2'b01, 2'b10, 2'b10};
    exp_a = '{64'h10000, 64'h11000, 64'h20000, 64'h21000};
`endif
    for (int b = 0; b < 4; b++) begin
      wait_req(20);
      chk($sformatf("arb%0d_addr", b), rd_addr_o, exp_a[b]);
      do_burst(g);
      chk($sformatf("arb%0d_gnt", b), 64'(g), 64'(exp_g[b]));
    end
    repeat (3) @(negedge clk);
    chk("arb_noreq", 64'(rd_req_o), 64'd0);
    dec_done_i = 2'b11;
    @(negedge clk);
    dec_done_i = 2'b00;
    chk("arb_idle", 64'(all_idle_o), 64'd1);

    // Zero-length jobs fill both slots; done frees a slot for the next job.
    job_valid_i = 1'b1;
    job_src_addr_i = 64'h3000;
    job_clen_i = 32'd0;
    @(negedge clk);
    chk("z_start0", 64'(dec_start_o), 64'b01);
    job_src_addr_i = 64'h4000;
    @(negedge clk);
    chk("z_start1", 64'(dec_start_o), 64'b10);
    chk("z_busy11", 64'(busy_o), 64'b11);
    chk("z_ready0", 64'(job_ready_o), 64'd0);
    @(negedge clk);
    chk("z_nostart", 64'(dec_start_o), 64'b00);
    chk("z_noreq", 64'(rd_req_o), 64'd0);
    dec_done_i = 2'b10;
    @(negedge clk);
    chk("z_busy01", 64'(busy_o), 64'b01);
    chk("z_ready1", 64'(job_ready_o), 64'd1);
    chk("z_nostart2", 64'(dec_start_o), 64'b00);
    dec_done_i = 2'b01;
    @(negedge clk);
    job_valid_i = 1'b0;
    dec_done_i = 2'b00;
    chk("z_start_d1", 64'(dec_start_o), 64'b10);
    chk("z_busy10", 64'(busy_o), 64'b10);
    @(negedge clk);
    chk("z_pulse1", 64'(dec_start_o), 64'b00);
    chk("z_noreq2", 64'(rd_req_o), 64'd0);
    dec_done_i = 2'b01;
    @(negedge clk);
    chk("z_ignore", 64'(busy_o), 64'b10);
    dec_done_i = 2'b10;
    @(negedge clk);
    dec_done_i = 2'b00;
    chk("z_idle", 64'(all_idle_o), 64'd1);

    // Asynchronous reset while in DATA.
    dec_almostempty_i = 2'b01;
    job(64'h5000, 32'd200);
    wait_req(20);
    rd_req_ack_i = 1'b1;
    @(negedge clk);
    rd_req_ack_i = 1'b0;
    chk("ar_gnt", 64'(rd_grant_o), 64'b01);
    #2 rst = 1'b1;
    #1;
    chk("ar_gnt0", 64'(rd_grant_o), 64'd0);
    chk("ar_busy", 64'(busy_o), 64'd0);
    chk("ar_idle", 64'(all_idle_o), 64'd1);
    chk("ar_ready", 64'(job_ready_o), 64'd1);
    chk("ar_req", 64'(rd_req_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_stay", 64'(all_idle_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
